// File: rtl/button_deb_pkg.sv
// ============================================================================
// Module  : button_deb_pkg
// Brief   : Shared state encodings and constants for the button debouncer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package button_deb_pkg;

    localparam int c_debounce_default = 16;
    localparam int c_state_w          = 2;

    typedef enum logic [c_state_w-1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // Counter must hold values up to and including the debounce length.
    function automatic int cnt_width(input int debounce_cycles);
        return $clog2(debounce_cycles + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/button_deb_if.sv
// ============================================================================
// Module  : button_deb_if
// Brief   : Button level in / validated-press pulse out bundle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface button_deb_if;

    logic button_in;
    logic button_valid;

    modport master (
        output button_in,
        input  button_valid
    );

    modport slave (
        input  button_in,
        output button_valid
    );

endinterface

`default_nettype wire

// File: rtl/button_deb_sync_2ff.sv
// ============================================================================
// Module  : sync_2ff
// Brief   : Two-flop single-bit synchronizer, async active-high reset to 0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_d,
    output logic      o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/button_deb.sv
// ============================================================================
// Module  : button_deb
// Brief   : Debounces a raw button and emits one registered pulse per press.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module button_deb
    import button_deb_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_debounce_default
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic button_in,
    output logic      button_valid
);

    localparam int                 c_cnt_w    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam bit                 c_single   = (DEBOUNCE_CYCLES == 1);

    logic               w_sync_in;
    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_valid;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (button_in),
        .o_q (w_sync_in)
    );

    // r_cnt holds the number of consecutive samples already seen at the
    // candidate level, so acceptance happens when it equals length-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_sync_in) begin
                        if (c_single) begin
                            r_state <= PRESSED;
                            r_cnt   <= '0;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= PRESS_WAIT;
                            r_cnt   <= c_cnt_one;
                        end
                    end
                end

                PRESS_WAIT: begin
                    if (!w_sync_in) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                        r_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end

                PRESSED: begin
                    // With a one-sample debounce the first low sample is
                    // already a complete release.
                    if (!w_sync_in) begin
                        if (c_single) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= RELEASE_WAIT;
                            r_cnt   <= c_cnt_one;
                        end
                    end
                end

                RELEASE_WAIT: begin
                    if (w_sync_in) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign button_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_button_deb.sv
// ============================================================================
// Module  : tb_button_deb
// Brief   : Self-checking bench for button_deb against a run-length model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_button_deb;
    import button_deb_pkg::*;

    localparam int N = 16;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    button_deb_if u_if ();

    button_deb #(.DEBOUNCE_CYCLES(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .button_in    (u_if.button_in),
        .button_valid (u_if.button_valid)
    );

    initial clk = 1'b0;
    always #5.26 clk = ~clk;

    // Reference: two-sample input delay, then an accepted level that flips
    // only after N consecutive samples at the opposite level.
    logic m_s1, m_s2, m_acc, m_exp;
    int   m_run;
    int   edge_cnt, pulse_cnt, pulse_edge;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_s1 = 1'b0; m_s2 = 1'b0; m_acc = 1'b0; m_exp = 1'b0; m_run = 0;
    endtask

    task automatic clear_counts();
        edge_cnt = 0; pulse_cnt = 0; pulse_edge = -1;
    endtask

    task automatic step(input logic b, input logic r);
        @(negedge clk);
        u_if.button_in = b;
        rst = r;
        @(posedge clk);
        #1;
        edge_cnt++;
        if (r) begin
            model_clear();
        end else begin
            m_exp = 1'b0;
            if ((m_s2 != m_acc)) m_run++;
            else m_run = 0;
            if (m_run == N) begin
                m_exp = !m_acc;
                m_acc = !m_acc;
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = b;
        end
        check("valid", u_if.button_valid, m_exp);
        if (u_if.button_valid === 1'b1) begin
            pulse_cnt++;
            pulse_edge = edge_cnt;
        end
    endtask

    task automatic hold(input logic b, input int n);
        for (int i = 0; i < n; i++) step(b, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        u_if.button_in = 1'b0;
        model_clear();
        clear_counts();

        // Reset held with a toggling input: output and state stay quiet.
        for (int i = 0; i < 11; i++) begin
            #1;
            u_if.button_in = ~u_if.button_in;
            check("rst_valid", u_if.button_valid, 0);
            check("rst_state", dut.r_state, IDLE);
        end
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        hold(1'b0, 4);

        // Clean press held 100 cycles.
        clear_counts();
        hold(1'b1, 100);
        check("clean_pulses", pulse_cnt, 1);
        check("clean_edge", pulse_edge, N + 2);

        // Bounce 5H/3L/10H/2L then steady high.
        hold(1'b0, 20);
        check("release_no_pulse", pulse_cnt, 1);
        clear_counts();
        hold(1'b1, 5); hold(1'b0, 3); hold(1'b1, 10); hold(1'b0, 2);
        check("bounce_quiet", pulse_cnt, 0);
        hold(1'b1, 30);
        check("bounce_pulses", pulse_cnt, 1);
        check("bounce_edge", pulse_edge, 20 + N + 2);

        // Short low glitch while pressed.
        clear_counts();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            check("glitch_not_idle", dut.r_state != IDLE, 1);
        end
        hold(1'b1, 30);
        check("glitch_pulses", pulse_cnt, 0);
        check("glitch_state", dut.r_state, PRESSED);

        // Full release then a second press.
        clear_counts();
        hold(1'b0, 20);
        check("release2_pulses", pulse_cnt, 0);
        check("release2_state", dut.r_state, IDLE);
        clear_counts();
        hold(1'b1, 30);
        check("repress_pulses", pulse_cnt, 1);
        check("repress_edge", pulse_edge, N + 2);

        // Asynchronous reset in the middle of a press debounce.
        hold(1'b0, 20);
        hold(1'b1, 12);
        check("pw_state", dut.r_state, PRESS_WAIT);
        check("pw_cnt", dut.r_cnt, 10);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", u_if.button_valid, 0);
        check("async_rst_state", dut.r_state, IDLE);
        check("async_rst_cnt", dut.r_cnt, 0);
        model_clear();
        clear_counts();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        check("during_rst_pulses", pulse_cnt, 0);
        clear_counts();
        hold(1'b1, 30);
        check("post_rst_pulses", pulse_cnt, 1);
        check("post_rst_edge", pulse_edge, N + 2);

        // Random runs of levels, checked cycle by cycle against the model.
        hold(1'b0, 20);
        for (int r = 0; r < 120; r++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = (($urandom_range(0, 3) == 0) ? int'($urandom_range(N, N + 8))
                                               : int'($urandom_range(1, N - 1)));
            hold(lvl, len);
        end
        hold(1'b0, 24);
        check("final_state", dut.r_state, IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/button_deb.md
BUTTON_DEB -- requirements
Module: button_deb

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, is the number of consecutive identical synchronized samples required to accept a level change; legal range is 1 to 65535.
REQ-002 clk, input, 1 bit: single system clock; all state changes on the rising edge.
REQ-003 rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 button_in, input, 1 bit: raw mechanical button level, asynchronous to clk; 1 means pressed.
REQ-005 button_valid, output, 1 bit: registered single-cycle pulse marking one validated press.
REQ-006 Port order SHALL be clk, rst, button_in, button_valid so that positional instantiation works.

Function
REQ-007 button_in SHALL pass through a 2-flop synchronizer; the FSM uses only the second-stage output, called sync_in.
REQ-008 The FSM SHALL have four states: IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-009 The counter width SHALL be $clog2(DEBOUNCE_CYCLES+1) bits.
REQ-010 IDLE: on sync_in=1, go to PRESS_WAIT with cnt=1; otherwise stay in IDLE.
REQ-011 PRESS_WAIT: on sync_in=0, go to IDLE and clear cnt (glitch rejected).
REQ-012 PRESS_WAIT: on sync_in=1 with cnt=DEBOUNCE_CYCLES-1, go to PRESSED and assert button_valid for the next cycle; otherwise increment cnt.
REQ-013 For DEBOUNCE_CYCLES=1, the transition IDLE->PRESSED SHALL occur directly on the first sync_in=1 sample.
REQ-014 PRESSED: on sync_in=0, go to RELEASE_WAIT with cnt=1; while held, no further pulses are generated.
REQ-015 RELEASE_WAIT: on sync_in=1, return to PRESSED and clear cnt, with no pulse.
REQ-016 RELEASE_WAIT: on sync_in=0 with cnt=DEBOUNCE_CYCLES-1, go to IDLE; otherwise increment cnt.
REQ-017 Release SHALL never generate a pulse.
REQ-018 Latency: with button_in rising before clock edge 1 and held, button_valid SHALL be 1 exactly between edges DEBOUNCE_CYCLES+2 and DEBOUNCE_CYCLES+3.
REQ-019 button_valid SHALL be high for exactly one clock per accepted press.
REQ-020 Any bounce shorter than DEBOUNCE_CYCLES samples SHALL produce no pulse.
REQ-021 The counter SHALL never exceed DEBOUNCE_CYCLES and SHALL never wrap.

Reset
REQ-022 While rst=1, both synchronizer flops and the counter SHALL be 0, the state SHALL be IDLE and button_valid SHALL be 0, independent of clk.
REQ-023 Reset asserted mid-debounce or mid-pulse SHALL abort it immediately, leaving no pending pulse.
REQ-024 If the button is still held after rst deasserts, a full new debounce SHALL occur and produce one pulse.

Structure
REQ-025 Package button_deb_pkg SHALL hold the 2-bit state encodings (IDLE=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3) and the default debounce constant.
REQ-026 A sub-module sync_2ff (1-bit, async active-high reset to 0) SHALL implement the synchronizer; the FSM and counter stay in button_deb.
REQ-027 There SHALL be no latches, no combinational path from button_in to button_valid, and no clock gating.

Verification (DEBOUNCE_CYCLES=16, clk period 10.52 ns)
REQ-028 Hold rst=1 for 11 time units with button_in toggling -> button_valid=0 and state IDLE throughout.
REQ-029 Clean press held 100 cycles after reset -> exactly one pulse, 1 cycle wide, at edge 18 after the rise.
REQ-030 Bounce pattern of 5 high/3 low/10 high/2 low, then steady high -> no pulse during the bounce, one pulse 16 sync samples after the last low.
REQ-031 Press accepted, then 5-cycle low glitch, then high again -> no second pulse and no return to IDLE.
REQ-032 Press accepted, release held 16 or more cycles, then press again -> second pulse; release itself pulses nothing.
REQ-033 Assert rst at cycle 10 of PRESS_WAIT while button_in stays high -> no pulse during reset; one pulse 18 edges after rst deasserts.
